// File: rtl/one_hot_index_encoder_pipe.sv
// Two-stage pipelined one-hot to index encoder with valid/ready handshake,
// zero/multi-hot detection and a saturating error counter.
module one_hot_index_encoder_pipe #(
  parameter int N          = 16,
  parameter bit SIGNED_OUT = 1'b1,
  parameter bit PRIORITY   = 1'b0,
  parameter int CNT_W      = 8,
  localparam int W         = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_w,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_idx,
  output logic             out_err,
  output logic             out_multi,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    CLS_ZERO  = 2'd0,
    CLS_ONE   = 2'd1,
    CLS_MULTI = 2'd2
  } cls_e;

  localparam logic [W-1:0] HALF = W'(N / 2);

  logic         s1_valid_r;
  logic [N-1:0] s1_w_r;
  cls_e         s1_cls_r;
  logic         s2_valid_r;
  logic         s1_adv_s;
  logic         s2_adv_s;
  logic [W-1:0] enc_idx_s;
  logic         enc_err_s;
  logic         enc_multi_s;

  // Clearing the lowest set bit leaves a non-zero word only for multi-hot input.
  function automatic cls_e classify(input logic [N-1:0] w);
    logic [N-1:0] low_clr;
    low_clr = w & (w - N'(1));
    if (w == '0) begin
      classify = CLS_ZERO;
    end else if (low_clr != '0) begin
      classify = CLS_MULTI;
    end else begin
      classify = CLS_ONE;
    end
  endfunction

  // Position of the most significant set bit.
  function automatic logic [W-1:0] top_pos(input logic [N-1:0] w);
    top_pos = '0;
    for (int i = 0; i < N; i++) begin
      if (w[i]) begin
        top_pos = W'(i);
      end
    end
  endfunction

  // N is a power of two, so N-1-p is ~p and subtracting N/2 flips the MSB.
  function automatic logic [W-1:0] pos_to_idx(input logic [W-1:0] p);
    logic [W-1:0] k;
    k = ~p;
    if (SIGNED_OUT) begin
      pos_to_idx = k ^ HALF;
    end else begin
      pos_to_idx = k;
    end
  endfunction

  // Handshake advance conditions; in_ready depends on out_ready but never in_valid.
  always_comb begin
    s2_adv_s = !s2_valid_r || out_ready;
    s1_adv_s = !s1_valid_r || s2_adv_s;
  end

  assign in_ready  = s1_adv_s;
  assign out_valid = s2_valid_r;

  // Encode the stage-1 word according to its class and the priority mode.
  always_comb begin
    enc_idx_s   = '0;
    enc_err_s   = 1'b0;
    enc_multi_s = 1'b0;
    case (s1_cls_r)
      CLS_ONE: begin
        enc_idx_s = pos_to_idx(top_pos(s1_w_r));
      end
      CLS_MULTI: begin
        enc_multi_s = 1'b1;
        if (PRIORITY) begin
          enc_idx_s = pos_to_idx(top_pos(s1_w_r));
        end else begin
          enc_err_s = 1'b1;
        end
      end
      default: begin
        enc_err_s = 1'b1;
      end
    endcase
  end

  // Stage 1: capture the accepted word and its popcount class.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_w_r     <= '0;
      s1_cls_r   <= CLS_ZERO;
    end else if (s1_adv_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_w_r   <= in_w;
        s1_cls_r <= classify(in_w);
      end
    end
  end

  // Stage 2: registered result, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      out_idx    <= '0;
      out_err    <= 1'b0;
      out_multi  <= 1'b0;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_idx   <= enc_idx_s;
        out_err   <= enc_err_s;
        out_multi <= enc_multi_s;
      end
    end
  end

  // Saturating count of delivered errored results; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr_cnt) begin
      err_cnt <= '0;
    end else if (s2_valid_r && out_ready && out_err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule
